// File: rtl/drone_pkg.sv
// Shared constants and helpers for the drone game datapath.
// Contents: default map/timer sizes, the register width helper and the
// seletor-to-lives mapping used by the configuration register.
package drone_pkg;

  localparam int unsigned N_LINHAS_PADRAO  = 4;
  localparam int unsigned N_COLUNAS_PADRAO = 16;
  localparam int unsigned T_LENTO_PADRAO   = 50_000_000;
  localparam int unsigned T_RAPIDO_PADRAO  = 25_000_000;

  // Width needed to index 0..n-1; never narrower than one bit.
  function automatic int unsigned largura(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned largura_linha(input int unsigned n_linhas);
    return largura(n_linhas);
  endfunction

  function automatic int unsigned largura_coluna(input int unsigned n_colunas);
    return largura(n_colunas);
  endfunction

  // Selector 0 would mean a game with no lives, so it is promoted to 1.
  function automatic logic [1:0] vidas_de_seletor(input logic [1:0] sel);
    return (sel == 2'd0) ? 2'd1 : sel;
  endfunction

endpackage

// File: rtl/drone_fluxo_dados_mapa.sv
// drone_mapa_rom: fixed obstacle map, one N_LINHAS-bit mask per column.
// Ports:
//   coluna_i     - map column being displayed/checked
//   obstaculos_o - obstacle mask of that column, bit r = obstacle on row r
module drone_mapa_rom
  import drone_pkg::*;
#(
  parameter int unsigned N_LINHAS  = N_LINHAS_PADRAO,
  parameter int unsigned N_COLUNAS = N_COLUNAS_PADRAO
) (
  input  logic [largura_coluna(N_COLUNAS)-1:0] coluna_i,
  output logic [N_LINHAS-1:0]                  obstaculos_o
);

  logic [3:0] base;

  always_comb begin
    case (int'(coluna_i))
      3:       base = 4'b0100;
      5:       base = 4'b0001;
      default: base = 4'b0000;
    endcase
    // Map is authored for four rows; extra rows are obstacle-free.
    obstaculos_o = '0;
    for (int i = 0; i < int'(N_LINHAS); i++) begin
      if (i < 4) obstaculos_o[i] = base[i[1:0]];
    end
  end

endmodule

// File: rtl/drone_fluxo_dados.sv
// drone_fluxo_dados: datapath of the drone game. Executes controller strobes
// and returns the status flags fim_espera, fim_mapa and colisao.
// Inputs : clock, reset (async, active-high), control strobes (zeraPosicoes,
//          contaT, zeraT, escolhe_modo, escolhe_vida, move_drone,
//          desloca_horizontal, resetaVidas), raw buttons, seletor.
// Outputs: status flags, linha, coluna, vidas, modo_rapido, obstaculos.
// Build option: DRONE_SINCRONIZA_BOTOES_EN adds a two-flop synchronizer on
// the buttons before edge detection (button-to-move latency 2 -> 4 cycles).
module drone_fluxo_dados
  import drone_pkg::*;
#(
  parameter int unsigned N_LINHAS  = N_LINHAS_PADRAO,
  parameter int unsigned N_COLUNAS = N_COLUNAS_PADRAO,
  parameter int unsigned T_LENTO   = T_LENTO_PADRAO,
  parameter int unsigned T_RAPIDO  = T_RAPIDO_PADRAO
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 zeraPosicoes,
  input  logic                                 contaT,
  input  logic                                 zeraT,
  input  logic                                 escolhe_modo,
  input  logic                                 escolhe_vida,
  input  logic                                 move_drone,
  input  logic                                 desloca_horizontal,
  input  logic                                 resetaVidas,
  input  logic                                 botao_cima,
  input  logic                                 botao_baixo,
  input  logic [1:0]                           seletor,
  output logic                                 fim_espera,
  output logic                                 fim_mapa,
  output logic                                 colisao,
  output logic [largura_linha(N_LINHAS)-1:0]   linha,
  output logic [largura_coluna(N_COLUNAS)-1:0] coluna,
  output logic [1:0]                           vidas,
  output logic                                 modo_rapido,
  output logic [N_LINHAS-1:0]                  obstaculos
);

  localparam int unsigned LW    = largura_linha(N_LINHAS);
  localparam int unsigned CW    = largura_coluna(N_COLUNAS);
  localparam int unsigned T_MAX = (T_LENTO > T_RAPIDO) ? T_LENTO : T_RAPIDO;
  localparam int unsigned TW    = largura(T_MAX);

  logic          modo_q, modo_d;
  logic [1:0]    cfg_q, cfg_d;
  logic [TW-1:0] t_q, t_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] lin_q, lin_d;
  logic [1:0]    vid_q, vid_d;
  logic          checa_q;
  logic          cima_prev_q, baixo_prev_q;
  logic          cima_edge_q, baixo_edge_q;
  logic          cima_s, baixo_s;
  logic [TW-1:0] lim_m1;
  logic          acerto;

`ifdef DRONE_SINCRONIZA_BOTOES_EN
  logic [1:0] cima_sync_q, baixo_sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cima_sync_q  <= '0;
      baixo_sync_q <= '0;
    end else begin
      cima_sync_q  <= {cima_sync_q[0], botao_cima};
      baixo_sync_q <= {baixo_sync_q[0], botao_baixo};
    end
  end

  assign cima_s  = cima_sync_q[1];
  assign baixo_s = baixo_sync_q[1];
`else
  assign cima_s  = botao_cima;
  assign baixo_s = botao_baixo;
`endif

  drone_mapa_rom #(
    .N_LINHAS  (N_LINHAS),
    .N_COLUNAS (N_COLUNAS)
  ) u_mapa (
    .coluna_i     (col_q),
    .obstaculos_o (obstaculos)
  );

  assign lim_m1 = modo_q ? TW'(T_RAPIDO - 1) : TW'(T_LENTO - 1);
  assign acerto = obstaculos[lin_q];

  always_comb begin
    modo_d = escolhe_modo ? seletor[0] : modo_q;
    cfg_d  = escolhe_vida ? vidas_de_seletor(seletor) : cfg_q;

    t_d = t_q;
    if (zeraT) t_d = '0;
    else if (contaT && (t_q < lim_m1)) t_d = t_q + TW'(1);

    col_d = col_q;
    if (zeraPosicoes) col_d = '0;
    else if (desloca_horizontal && (col_q != CW'(N_COLUNAS - 1))) col_d = col_q + CW'(1);

    // Simultaneous up and down edges cancel out.
    lin_d = lin_q;
    if (zeraPosicoes) begin
      lin_d = LW'(N_LINHAS / 2);
    end else if (move_drone && (cima_edge_q != baixo_edge_q)) begin
      if (cima_edge_q && (lin_q != '0)) lin_d = lin_q - LW'(1);
      else if (baixo_edge_q && (lin_q != LW'(N_LINHAS - 1))) lin_d = lin_q + LW'(1);
    end

    // Lives are intentionally not reloaded by zeraPosicoes.
    vid_d = vid_q;
    if (resetaVidas) vid_d = cfg_q;
    else if (checa_q && acerto && (vid_q != 2'd0)) vid_d = vid_q - 2'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      modo_q       <= 1'b0;
      cfg_q        <= 2'd3;
      t_q          <= '0;
      col_q        <= '0;
      lin_q        <= LW'(N_LINHAS / 2);
      vid_q        <= 2'd3;
      checa_q      <= 1'b0;
      cima_prev_q  <= 1'b0;
      baixo_prev_q <= 1'b0;
      cima_edge_q  <= 1'b0;
      baixo_edge_q <= 1'b0;
    end else begin
      modo_q       <= modo_d;
      cfg_q        <= cfg_d;
      t_q          <= t_d;
      col_q        <= col_d;
      lin_q        <= lin_d;
      vid_q        <= vid_d;
      checa_q      <= desloca_horizontal;
      cima_prev_q  <= cima_s;
      baixo_prev_q <= baixo_s;
      cima_edge_q  <= cima_s & ~cima_prev_q;
      baixo_edge_q <= baixo_s & ~baixo_prev_q;
    end
  end

  assign fim_espera  = contaT && (t_q == lim_m1);
  assign fim_mapa    = (col_q == CW'(N_COLUNAS - 1));
  // Uses the pre-decrement lives: the last life lost is the fatal one.
  assign colisao     = checa_q && acerto && (vid_q <= 2'd1);
  assign linha       = lin_q;
  assign coluna      = col_q;
  assign vidas       = vid_q;
  assign modo_rapido = modo_q;

endmodule

// File: tb/tb_drone_fluxo_dados.sv
// Bench for drone_fluxo_dados: directed scenarios with literal expectations,
// then randomized strobes/buttons, all checked every cycle against a
// behavioural model of the game rules.
module tb_drone_fluxo_dados;

  localparam int NL = 4;
  localparam int NC = 16;
  localparam int TL = 6;
  localparam int TR = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic zeraPosicoes = 0, contaT = 0, zeraT = 0, escolhe_modo = 0, escolhe_vida = 0;
  logic move_drone = 0, desloca_horizontal = 0, resetaVidas = 0;
  logic botao_cima = 0, botao_baixo = 0;
  logic [1:0] seletor = 0;
  logic fim_espera, fim_mapa, colisao, modo_rapido;
  logic [1:0] linha, vidas;
  logic [3:0] coluna, obstaculos;

  int vectors = 0;
  int miscompares = 0;

  // Model state, in plain game terms.
  int m_modo, m_cfg, m_t, m_col, m_lin, m_vid, m_checa;
  int m_cima_last, m_baixo_last, m_up_pend, m_dn_pend;

  drone_fluxo_dados #(
    .N_LINHAS  (NL),
    .N_COLUNAS (NC),
    .T_LENTO   (TL),
    .T_RAPIDO  (TR)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .zeraPosicoes       (zeraPosicoes),
    .contaT             (contaT),
    .zeraT              (zeraT),
    .escolhe_modo       (escolhe_modo),
    .escolhe_vida       (escolhe_vida),
    .move_drone         (move_drone),
    .desloca_horizontal (desloca_horizontal),
    .resetaVidas        (resetaVidas),
    .botao_cima         (botao_cima),
    .botao_baixo        (botao_baixo),
    .seletor            (seletor),
    .fim_espera         (fim_espera),
    .fim_mapa           (fim_mapa),
    .colisao            (colisao),
    .linha              (linha),
    .coluna             (coluna),
    .vidas              (vidas),
    .modo_rapido        (modo_rapido),
    .obstaculos         (obstaculos)
  );

  always #5 clock = ~clock;

  function automatic int mapa(input int col);
    if (col == 3) return 4;  // 0100
    if (col == 5) return 1;  // 0001
    return 0;
  endfunction

  task automatic cmp(input string nome, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: next state from the game rules.
  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_modo = 0; m_cfg = 3; m_t = 0; m_col = 0; m_lin = NL / 2; m_vid = 3;
        m_checa = 0; m_cima_last = 0; m_baixo_last = 0; m_up_pend = 0; m_dn_pend = 0;
      end else begin
        int lim, hit, nlin, nvid;
        lim  = m_modo ? TR : TL;
        hit  = (mapa(m_col) >> m_lin) & 1;
        nlin = m_lin;
        if (zeraPosicoes) nlin = NL / 2;
        else if (move_drone && m_up_pend && !m_dn_pend) nlin = (m_lin > 0) ? m_lin - 1 : 0;
        else if (move_drone && m_dn_pend && !m_up_pend) nlin = (m_lin < NL - 1) ? m_lin + 1 : NL - 1;
        nvid = m_vid;
        if (resetaVidas) nvid = m_cfg;
        else if (m_checa && hit && m_vid > 0) nvid = m_vid - 1;
        if (zeraT) m_t = 0;
        else if (contaT && m_t < lim - 1) m_t = m_t + 1;
        if (zeraPosicoes) m_col = 0;
        else if (desloca_horizontal && m_col < NC - 1) m_col = m_col + 1;
        m_lin = nlin;
        m_vid = nvid;
        m_checa = desloca_horizontal;
        m_up_pend = botao_cima && !m_cima_last;
        m_dn_pend = botao_baixo && !m_baixo_last;
        m_cima_last = botao_cima;
        m_baixo_last = botao_baixo;
        if (escolhe_modo) m_modo = seletor[0];
        if (escolhe_vida) m_cfg = (seletor == 0) ? 1 : seletor;
      end
    end
  end

  // Compare process: every negedge once the model has been reset.
  initial begin
    @(posedge reset);
    forever begin
      int lim, msk, hit;
      @(negedge clock);
      lim = m_modo ? TR : TL;
      msk = mapa(m_col);
      hit = (msk >> m_lin) & 1;
      cmp("fim_espera", fim_espera, (contaT && m_t == lim - 1) ? 1 : 0);
      cmp("fim_mapa", fim_mapa, (m_col == NC - 1) ? 1 : 0);
      cmp("colisao", colisao, (m_checa && hit && m_vid <= 1) ? 1 : 0);
      cmp("linha", linha, m_lin);
      cmp("coluna", coluna, m_col);
      cmp("vidas", vidas, m_vid);
      cmp("modo_rapido", modo_rapido, m_modo);
      cmp("obstaculos", obstaculos, msk);
    end
  end

  initial begin
    #2 reset = 1'b1;
    @(negedge clock);
    cmp("rst_linha", linha, 2);
    cmp("rst_vidas", vidas, 3);
    cmp("rst_coluna", coluna, 0);
    cmp("rst_modo", modo_rapido, 0);
    cmp("rst_colisao", colisao, 0);
    tick();
    reset = 1'b0;

    // Configuration: fast mode, lives selector 0 -> 1.
    seletor = 2'd1; escolhe_modo = 1; tick();
    escolhe_modo = 0; seletor = 2'd0; escolhe_vida = 1; tick();
    escolhe_vida = 0; resetaVidas = 1; tick();
    resetaVidas = 0;
    @(negedge clock);
    cmp("cfg_modo", modo_rapido, 1);
    cmp("cfg_vidas", vidas, 1);

    // Timer in fast mode: fim_espera on the 4th contaT cycle.
    tick();
    zeraT = 1; tick();
    zeraT = 0; contaT = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      cmp("timer_fim", fim_espera, (i == 4) ? 1 : 0);
      tick();
    end
    contaT = 0;

    // Rows: three up-edges saturate at 0, an edge without move_drone is lost.
    zeraPosicoes = 1; tick();
    zeraPosicoes = 0;
    @(negedge clock);
    cmp("linha_zera", linha, 2);
    tick();
    move_drone = 1;
    for (int k = 0; k < 3; k++) begin
      botao_cima = 1; tick();
      botao_cima = 0; tick();
    end
    @(negedge clock);
    cmp("linha_sat0", linha, 0);
    tick();
    move_drone = 0;
    botao_baixo = 1; tick();
    botao_baixo = 0; tick(); tick();
    @(negedge clock);
    cmp("linha_sem_move", linha, 0);
    tick();

    // Non-fatal hit with 3 lives at column 3, row 2.
    seletor = 2'd3; escolhe_vida = 1; tick();
    escolhe_vida = 0; resetaVidas = 1; tick();
    resetaVidas = 0; zeraPosicoes = 1; tick();
    zeraPosicoes = 0; desloca_horizontal = 1; tick(); tick(); tick();
    desloca_horizontal = 0;
    @(negedge clock);
    cmp("hit3_colisao", colisao, 0);
    tick();
    @(negedge clock);
    cmp("hit3_vidas", vidas, 2);
    tick();

    // Fatal hit with 1 life.
    seletor = 2'd1; escolhe_vida = 1; tick();
    escolhe_vida = 0; resetaVidas = 1; tick();
    resetaVidas = 0; zeraPosicoes = 1; tick();
    zeraPosicoes = 0; desloca_horizontal = 1; tick(); tick(); tick();
    desloca_horizontal = 0;
    @(negedge clock);
    cmp("hit1_colisao", colisao, 1);
    tick();
    @(negedge clock);
    cmp("hit1_colisao_fim", colisao, 0);
    cmp("hit1_vidas", vidas, 0);
    tick();

    // Traverse to the last column on row 1 (no obstacles there).
    zeraPosicoes = 1; tick();
    zeraPosicoes = 0; move_drone = 1; botao_cima = 1; tick();
    botao_cima = 0; tick();
    move_drone = 0;
    desloca_horizontal = 1;
    for (int k = 0; k < 15; k++) tick();
    desloca_horizontal = 0;
    @(negedge clock);
    cmp("fim_coluna", coluna, 15);
    cmp("fim_mapa_lit", fim_mapa, 1);
    tick();
    desloca_horizontal = 1; tick();
    desloca_horizontal = 0;
    @(negedge clock);
    cmp("coluna_sat", coluna, 15);
    tick();

    // Randomized phase.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        botao_cima = 0; botao_baixo = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      zeraPosicoes       = ($urandom_range(0, 19) == 0);
      zeraT              = ($urandom_range(0, 9) == 0);
      contaT             = ($urandom_range(0, 3) != 0);
      escolhe_modo       = ($urandom_range(0, 15) == 0);
      escolhe_vida       = ($urandom_range(0, 15) == 0);
      resetaVidas        = ($urandom_range(0, 15) == 0);
      move_drone         = ($urandom_range(0, 1) == 1);
      desloca_horizontal = ($urandom_range(0, 2) == 0);
      seletor            = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) botao_cima = ~botao_cima;
      if ($urandom_range(0, 2) == 0) botao_baixo = ~botao_baixo;
      tick();
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
